// File: rtl/serial_tx8_if.sv
// Parallel-load / serial-out bus for serial_tx8: the data word and load request go in,
// and the serial line and frame status come back out.
interface serial_tx8_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] Din;
  logic             Load;
  logic             SOut;
  logic             Busy;
  logic             Done;

  modport master (output Din, Load, input SOut, Busy, Done);
  modport slave  (input Din, Load, output SOut, Busy, Done);
endinterface

// File: rtl/serial_tx8.sv
// Frame serializer: Load in IDLE starts a frame of WIDTH bits, sent LSB first, then one Done cycle.
// Latency: the first bit appears the cycle after the capture edge. Load is ignored while a frame is in flight.
module serial_tx8 #(
  parameter int WIDTH = 8
) (
  input  logic         Clk,
  input  logic         R,
  serial_tx8_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]   cnt;
  logic            sout;
  logic            busy;
  logic            done;

  // The bit on the line is held in sout; sreg holds only the bits still waiting to go out.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      sout  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Load) begin
            sreg  <= bus.Din >> 1;
            sout  <= bus.Din[0];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            sout  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sreg <= sreg >> 1;
            sout <= sreg[0];
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          sout  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.SOut = sout;
  assign bus.Busy = busy;
  assign bus.Done = done;
endmodule

// File: tb/tb_serial_tx8.sv
// Drives a WIDTH=8 and a WIDTH=2 serializer with the same stimulus and checks every cycle
// against a queue of expected line states built from each accepted frame.
module tb_serial_tx8;
  logic Clk = 1'b0;
  logic R;

  always #5 Clk = ~Clk;

  serial_tx8_if #(.WIDTH(8)) b8 ();
  serial_tx8_if #(.WIDTH(2)) b2 ();

  serial_tx8 #(.WIDTH(8)) u8 (.Clk(Clk), .R(R), .bus(b8));
  serial_tx8 #(.WIDTH(2)) u2 (.Clk(Clk), .R(R), .bus(b2));

  int tests = 0;
  int fails = 0;

  // Expected per-cycle {SOut, Busy, Done}; an empty queue means the line is idle.
  logic [2:0] q8[$];
  logic [2:0] q2[$];
  logic       wd8 = 1'b0;
  logic       wd2 = 1'b0;
  logic [2:0] e8;
  logic [2:0] e2;
  logic [7:0] bits;

  localparam logic [2:0] IDLE_LINE = 3'b100;
  localparam logic [2:0] DONE_LINE = 3'b101;

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed={SOut,Busy,Done}=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A frame is accepted only when the line is idle and the previous cycle was not the Done cycle.
  task automatic model_edge(input logic ld, input logic [7:0] d);
    if (q8.size() == 0 && !wd8 && ld) begin
      for (int i = 0; i < 8; i++) q8.push_back({d[i], 1'b1, 1'b0});
      q8.push_back(DONE_LINE);
    end
    if (q2.size() == 0 && !wd2 && ld) begin
      for (int i = 0; i < 2; i++) q2.push_back({d[i], 1'b1, 1'b0});
      q2.push_back(DONE_LINE);
    end
    e8  = (q8.size() != 0) ? q8.pop_front() : IDLE_LINE;
    e2  = (q2.size() != 0) ? q2.pop_front() : IDLE_LINE;
    wd8 = (e8 == DONE_LINE);
    wd2 = (e2 == DONE_LINE);
  endtask

  task automatic step(input logic ld, input logic [7:0] d);
    b8.Load = ld;
    b8.Din  = d;
    b2.Load = ld;
    b2.Din  = d[1:0];
    @(posedge Clk);
    model_edge(ld, d);
    #1;
    check3("w8_line", {b8.SOut, b8.Busy, b8.Done}, e8);
    check3("w2_line", {b2.SOut, b2.Busy, b2.Done}, e2);
  endtask

  // Called 1ns after an edge: asserts reset mid-cycle, checks the outputs fall back at once.
  task automatic mid_reset();
    #3;
    R = 1'b0;
    #1;
    q8.delete();
    q2.delete();
    wd8 = 1'b0;
    wd2 = 1'b0;
    check3("w8_async_rst", {b8.SOut, b8.Busy, b8.Done}, IDLE_LINE);
    check3("w2_async_rst", {b2.SOut, b2.Busy, b2.Done}, IDLE_LINE);
    b8.Load = 1'b1;
    b2.Load = 1'b1;
    @(posedge Clk);
    #1;
    check3("w8_held_rst", {b8.SOut, b8.Busy, b8.Done}, IDLE_LINE);
    check3("w2_held_rst", {b2.SOut, b2.Busy, b2.Done}, IDLE_LINE);
    #2;
    R = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    R       = 1'b1;
    b8.Load = 1'b0;
    b8.Din  = '0;
    b2.Load = 1'b0;
    b2.Din  = '0;
    #1 R = 1'b0;
    #1;
    check3("w8_reset", {b8.SOut, b8.Busy, b8.Done}, IDLE_LINE);
    check3("w2_reset", {b2.SOut, b2.Busy, b2.Done}, IDLE_LINE);
    @(posedge Clk);
    #1;
    check3("w8_reset_edge", {b8.SOut, b8.Busy, b8.Done}, IDLE_LINE);
    #2 R = 1'b1;
    step(1'b0, 8'h00);

    // Basic A5 frame, bits collected off the line and compared as a word.
    step(1'b1, 8'hA5);
    bits[0] = b8.SOut;
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 8'h00);
      bits[i] = b8.SOut;
    end
    check8("a5_serial_word", bits, 8'hA5);
    step(1'b0, 8'h00);
    check3("a5_done_cycle", {b8.SOut, b8.Busy, b8.Done}, DONE_LINE);
    step(1'b0, 8'h00);

    // Load and a new Din mid-frame are ignored.
    step(1'b1, 8'h0F);
    bits[0] = b8.SOut;
    for (int i = 1; i < 8; i++) begin
      step((i == 3), (i >= 3) ? 8'hFF : 8'h0F);
      bits[i] = b8.SOut;
    end
    check8("busy_ignore_word", bits, 8'h0F);
    for (int i = 0; i < 4; i++) step(1'b0, 8'hFF);

    // Load held high: back-to-back frames separated by Done plus one idle cycle.
    step(1'b1, 8'h81);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h7E);
    step(1'b0, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00);

    // Reset in the middle of an all-zero frame, then a clean frame.
    step(1'b1, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    mid_reset();
    step(1'b1, 8'h3C);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);

    // Constant-bit frames; Din low bits 2'b10 exercise the narrow instance.
    step(1'b1, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h02);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check3("w2_done_cycle3", {b2.SOut, b2.Busy, b2.Done}, DONE_LINE);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 70) == 0) mid_reset();
      step($urandom_range(0, 3) == 0, 8'($urandom));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_tx8.md
SERIAL_TX8 -- requirements
Module: serial_tx8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame (legal range 2..16).
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port R, input, 1 bit: asynchronous, active-low reset (R=0 resets).
REQ-004 SHALL have port Din, input, WIDTH bits: parallel data word to transmit.
REQ-005 SHALL have port Load, input, 1 bit: request to start a frame with the current Din.
REQ-006 SHALL have port SOut, output, 1 bit: serial data line, LSB first, idles high.
REQ-007 SHALL have port Busy, output, 1 bit: high while a frame is in progress.
REQ-008 SHALL have port Done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-009 SHALL register all outputs (SOut, Busy, Done); no combinational path from any input to any output.
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE: SHALL drive SOut=1, Busy=0, Done=0.
REQ-012 IDLE with Load=1 at edge k: SHALL capture Din into a WIDTH-bit shift register, clear the bit counter and enter SHIFT.
REQ-013 SHIFT: SHALL drive SOut = Din[i] during cycle k+1+i for i = 0..WIDTH-1, with Busy=1 throughout.
REQ-014 SHIFT: SHALL shift the register right by one bit and increment the counter on each edge; the counter SHALL be ceil(log2(WIDTH)) bits wide.
REQ-015 SHIFT: on the edge ending bit WIDTH-1, SHALL enter DONE; the counter SHALL never wrap within a frame.
REQ-016 DONE: SHALL last exactly one cycle (cycle k+WIDTH+1), with Done=1, Busy=0 and SOut=1, then return to IDLE.
REQ-017 Load SHALL be ignored in SHIFT and DONE; Din changes after the capture edge SHALL NOT affect the frame in progress.
REQ-018 Load held high continuously SHALL start a new frame at the first IDLE edge (k+WIDTH+2), so frames are spaced at WIDTH+2 cycles with one idle-high cycle between them.
REQ-019 Load=0 in IDLE SHALL hold all state unchanged.

Reset
REQ-020 R=0 SHALL immediately, independent of Clk, force: state=IDLE, shift register=0, counter=0, SOut=1, Busy=0, Done=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no Done pulse; the remaining bits are discarded.
REQ-022 After R returns to 1, the first Load SHALL be honoured on the first rising Clk edge at which R=1 and Load=1.

Verification
REQ-023 Basic frame: WIDTH=8, Din=8'hA5, Load pulse at edge 0 -> SOut = 1,0,1,0,0,1,0,1 in cycles 1..8; Done=1 only in cycle 9; Busy=1 in cycles 1..8.
REQ-024 Load ignored while busy: Din=8'h0F, Load at edge 0; Din=8'hFF with Load=1 at edge 3 -> serial output is 8'h0F only, and no second frame starts.
REQ-025 Back-to-back: Load held at 1 with Din=8'h81, then 8'h7E -> second frame's first bit appears in cycle 11; SOut=1 in cycles 9 and 10.
REQ-026 Mid-frame reset: Din=8'h00, Load at edge 0, R=0 asynchronously in cycle 4 -> SOut=1 and Busy=0 at once; Done never asserts; a new Load after R=1 transmits correctly.
REQ-027 Extremes: Din=8'h00 and 8'hFF -> eight constant bits followed by a Done pulse; WIDTH=2 with Din=2'b10 -> SOut = 0,1, then Done in cycle 3.
